// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back D-cache controller (tag/valid/dirty state, miss FSM, optional DCACHE_CTRL_STATS_EN counters).
// Latency: hit/stall resolved combinationally in the request cycle; a miss costs an optional writeback burst plus a refill burst.
// Backpressure: o_stall_cache holds the pipeline through a miss; memory requests stay asserted and stable until i_mem_req_ready.
module dcache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 4
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic                i_req_valid,
    input  logic                i_req_we,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                o_stall_cache,
    output logic                o_hit,
    output logic                o_mem_req_valid,
    output logic                o_mem_req_we,
    output logic [ADDR_W-1:0]   o_mem_req_addr,
    input  logic                i_mem_req_ready,
    input  logic                i_mem_beat_valid,
    output logic                o_data_we,
    output logic                o_data_src,
    output logic [INDEX_W-1:0]  o_data_index,
    output logic [OFFSET_W-1:0] o_data_word,
    output logic [31:0]         o_hit_count,
    output logic [31:0]         o_miss_count
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int SETS  = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_DATA,
        FILL_REQ,
        FILL_DATA
    } state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]    tag_q [SETS];
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic [TAG_W-1:0]    miss_tag_q;
    logic [INDEX_W-1:0]  miss_idx_q;
    logic [OFFSET_W-1:0] beat_cnt_q;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_word;
    logic                unused_addr_lsb;

    logic hit;
    logic miss_start;
    logic store_hit;
    logic fill_done;
    logic cnt_en;

    assign req_tag         = i_req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx         = i_req_addr[INDEX_W+OFFSET_W+1 : OFFSET_W+2];
    assign req_word        = i_req_addr[OFFSET_W+1 : 2];
    assign unused_addr_lsb = ^i_req_addr[1:0];

    always_comb begin
        state_d         = state_q;
        hit             = 1'b0;
        miss_start      = 1'b0;
        store_hit       = 1'b0;
        fill_done       = 1'b0;
        cnt_en          = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_req_we    = 1'b0;
        o_mem_req_addr  = '0;
        o_data_we       = 1'b0;
        o_data_src      = 1'b0;
        o_data_index    = '0;
        o_data_word     = '0;

        case (state_q)
            IDLE: begin
                hit = i_req_valid & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
                if (hit) begin
                    o_data_index = req_idx;
                    o_data_word  = req_word;
                    if (i_req_we) begin
                        o_data_we = 1'b1;
                        store_hit = 1'b1;
                    end
                end else if (i_req_valid) begin
                    miss_start = 1'b1;
                    // A dirty victim must reach memory before its frame is overwritten.
                    state_d = (valid_q[req_idx] & dirty_q[req_idx]) ? WB_REQ : FILL_REQ;
                end
            end
            WB_REQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_we    = 1'b1;
                o_mem_req_addr  = {tag_q[miss_idx_q], miss_idx_q, {(OFFSET_W+2){1'b0}}};
                if (i_mem_req_ready) begin
                    state_d = WB_DATA;
                end
            end
            WB_DATA: begin
                o_data_index = miss_idx_q;
                o_data_word  = beat_cnt_q;
                cnt_en       = i_mem_beat_valid;
                if (i_mem_beat_valid && (&beat_cnt_q)) begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_we    = 1'b0;
                o_mem_req_addr  = {miss_tag_q, miss_idx_q, {(OFFSET_W+2){1'b0}}};
                if (i_mem_req_ready) begin
                    state_d = FILL_DATA;
                end
            end
            FILL_DATA: begin
                o_data_index = miss_idx_q;
                o_data_word  = beat_cnt_q;
                o_data_src   = 1'b1;
                o_data_we    = i_mem_beat_valid;
                cnt_en       = i_mem_beat_valid;
                if (i_mem_beat_valid && (&beat_cnt_q)) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_hit         = hit;
    assign o_stall_cache = ((state_q == IDLE) & i_req_valid & ~hit) | (state_q != IDLE);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_tag_q <= req_tag;
                miss_idx_q <= req_idx;
            end
            if (cnt_en) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (store_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tags are only trusted behind valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end

`ifdef DCACHE_CTRL_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign o_hit_count  = hit_cnt_q;
    assign o_miss_count = miss_cnt_q;
`else
    assign o_hit_count  = 32'd0;
    assign o_miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a set-level cache model (tags, valid, dirty per set) plus directed corner cases.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic        o_stall_cache;
    logic        o_hit;
    logic        o_mem_req_valid;
    logic        o_mem_req_we;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_req_ready = 1'b0;
    logic        i_mem_beat_valid = 1'b0;
    logic        o_data_we;
    logic        o_data_src;
    logic [3:0]  o_data_index;
    logic [3:0]  o_data_word;
    logic [31:0] o_hit_count;
    logic [31:0] o_miss_count;

    dcache_ctrl dut (
        .clk              (clk),
        .arstn            (arstn),
        .i_req_valid      (i_req_valid),
        .i_req_we         (i_req_we),
        .i_req_addr       (i_req_addr),
        .o_stall_cache    (o_stall_cache),
        .o_hit            (o_hit),
        .o_mem_req_valid  (o_mem_req_valid),
        .o_mem_req_we     (o_mem_req_we),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_req_ready  (i_mem_req_ready),
        .i_mem_beat_valid (i_mem_beat_valid),
        .o_data_we        (o_data_we),
        .o_data_src       (o_data_src),
        .o_data_index     (o_data_index),
        .o_data_word      (o_data_word),
        .o_hit_count      (o_hit_count),
        .o_miss_count     (o_miss_count)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference cache state: what each set holds, independent of any FSM.
    logic [21:0] mtag   [16];
    bit          mvalid [16];
    bit          mdirty [16];
    int          exp_hits = 0;
    int          exp_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef DCACHE_CTRL_STATS_EN
        chk("hit_count", o_hit_count, 32'(exp_hits));
        chk("miss_count", o_miss_count, 32'(exp_miss));
`else
        chk("hit_count_off", o_hit_count, 32'd0);
        chk("miss_count_off", o_miss_count, 32'd0);
`endif
    endtask

    function automatic logic [31:0] mk_addr(input int tag, input int idx, input int word);
        return (32'(tag) << 10) | (32'(idx) << 6) | (32'(word) << 2);
    endfunction

    // Called just after a negedge; asserts reset immediately and checks the async clear.
    task automatic assert_reset();
        arstn = 1'b0;
        #1;
        i_mem_beat_valid = 1'b0;
        i_mem_req_ready  = 1'b0;
        #1;
        chk("rst_stall", {31'd0, o_stall_cache}, {31'd0, i_req_valid});
        chk("rst_hit", {31'd0, o_hit}, 32'd0);
        chk("rst_mreq_valid", {31'd0, o_mem_req_valid}, 32'd0);
        chk("rst_data_we", {31'd0, o_data_we}, 32'd0);
        for (int s = 0; s < 16; s++) begin
            mvalid[s] = 1'b0;
            mdirty[s] = 1'b0;
        end
        exp_hits = 0;
        exp_miss = 0;
        chk_stats();
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
    endtask

    // One memory burst: request phase with ready held off `dly` cycles, then 16 beats with random gaps.
    task automatic mem_phase(input bit wb, input logic [31:0] exp_addr, input int idx,
                             input int dly, input bit junk, input bit drop);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            if (drop) begin
                i_req_valid = 1'($urandom_range(0, 1));
                i_req_addr  = $urandom & 32'hFFFF_FFFC;
            end
            i_mem_req_ready  = (c == dly);
            i_mem_beat_valid = junk && (c < dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            chk(wb ? "wbreq_valid" : "fillreq_valid", {31'd0, o_mem_req_valid}, 32'd1);
            chk(wb ? "wbreq_we" : "fillreq_we", {31'd0, o_mem_req_we}, {31'd0, wb});
            chk(wb ? "wbreq_addr" : "fillreq_addr", o_mem_req_addr, exp_addr);
            chk("req_stall", {31'd0, o_stall_cache}, 32'd1);
            chk("req_data_we", {31'd0, o_data_we}, 32'd0);
        end
        for (int k = 0; k < 16;) begin
            @(negedge clk);
            if (drop) begin
                i_req_valid = 1'($urandom_range(0, 1));
                i_req_addr  = $urandom & 32'hFFFF_FFFC;
            end
            i_mem_req_ready  = 1'($urandom_range(0, 1));
            i_mem_beat_valid = ($urandom_range(0, 2) != 0);
            #1;
            chk("data_stall", {31'd0, o_stall_cache}, 32'd1);
            chk("data_hit", {31'd0, o_hit}, 32'd0);
            chk("data_mreq_valid", {31'd0, o_mem_req_valid}, 32'd0);
            chk(wb ? "wb_word" : "fill_word", {28'd0, o_data_word}, 32'(k));
            chk(wb ? "wb_index" : "fill_index", {28'd0, o_data_index}, 32'(idx));
            chk(wb ? "wb_data_we" : "fill_data_we", {31'd0, o_data_we},
                {31'd0, (!wb && i_mem_beat_valid)});
            if (!wb && i_mem_beat_valid) begin
                chk("fill_src", {31'd0, o_data_src}, 32'd1);
            end
            if (i_mem_beat_valid) k++;
        end
    endtask

    task automatic present(input logic [31:0] a, input logic w, input bit exp_hit);
        int idx = int'(a[9:6]);
        @(negedge clk);
        i_mem_req_ready  = 1'b0;
        i_mem_beat_valid = 1'b0;
        i_req_valid      = 1'b1;
        i_req_we         = w;
        i_req_addr       = a;
        #1;
        chk_stats();
        chk("hit", {31'd0, o_hit}, {31'd0, exp_hit});
        chk("stall", {31'd0, o_stall_cache}, {31'd0, !exp_hit});
        if (exp_hit) begin
            exp_hits++;
            chk("hit_data_we", {31'd0, o_data_we}, {31'd0, w});
            if (w) begin
                chk("st_src", {31'd0, o_data_src}, 32'd0);
                chk("st_index", {28'd0, o_data_index}, 32'(idx));
                chk("st_word", {28'd0, o_data_word}, {28'd0, a[5:2]});
                mdirty[idx] = 1'b1;
            end
        end else begin
            exp_miss++;
        end
    endtask

    task automatic access(input logic [31:0] a, input logic w, input int dly,
                          input bit junk, input bit drop);
        int idx = int'(a[9:6]);
        logic [21:0] tag = a[31:10];
        bit mhit = mvalid[idx] && (mtag[idx] == tag);
        present(a, w, mhit);
        if (!mhit) begin
            if (mvalid[idx] && mdirty[idx]) begin
                mem_phase(1'b1, {mtag[idx], a[9:6], 6'd0}, idx, dly, junk, drop);
            end
            mem_phase(1'b0, {tag, a[9:6], 6'd0}, idx, dly, junk, drop);
            mtag[idx]   = tag;
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
            present(a, w, 1'b1);
        end
    endtask

    initial begin
        @(negedge clk);
        assert_reset();

        // Cold load miss, immediate grant, then hit on re-present.
        access(32'h0000_1040, 1'b0, 0, 1'b0, 1'b0);
        // Store hit dirties set 1; conflicting load forces writeback then refill with stalled grants and stray beats.
        access(32'h0000_1044, 1'b1, 0, 1'b0, 1'b0);
        access(32'h0000_2040, 1'b0, 10, 1'b1, 1'b0);
        // Request withdrawn while the miss is in flight.
        access(32'h0000_1040, 1'b0, 2, 1'b1, 1'b1);
        access(32'h0000_1048, 1'b0, 0, 1'b0, 1'b0);

        // Reset during refill beat 5 must leave the set invalid.
        @(negedge clk);
        assert_reset();
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_req_addr  = 32'h0000_1040;
        #1;
        chk("r31_stall", {31'd0, o_stall_cache}, 32'd1);
        @(negedge clk);
        i_mem_req_ready = 1'b1;
        #1;
        chk("r31_fill_addr", o_mem_req_addr, 32'h0000_1040);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            i_mem_req_ready  = 1'b0;
            i_mem_beat_valid = 1'b1;
            #1;
            chk("r31_word", {28'd0, o_data_word}, 32'(k));
        end
        assert_reset();
        access(32'h0000_1040, 1'b0, 1, 1'b0, 1'b0);
        access(32'h0000_1050, 1'b0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            access(mk_addr($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        i_req_valid = 1'b0;
        #1;
        chk_stats();
        chk("idle_stall", {31'd0, o_stall_cache}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter INDEX_W, default 4, set-index bits (direct-mapped, 2^INDEX_W sets).
REQ-003 SHALL have parameter OFFSET_W, default 4, word-offset bits (block = 2^OFFSET_W 32-bit words); tag width = ADDR_W-INDEX_W-OFFSET_W-2.
REQ-004 SHALL have ports: clk in 1 clock; arstn in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: i_req_valid in 1 MEM-stage access; i_req_we in 1 store; i_req_addr in ADDR_W byte address.
REQ-006 SHALL have ports: o_stall_cache out 1 stall to hazard unit; o_hit out 1 lookup hit.
REQ-007 SHALL have ports: o_mem_req_valid out 1; o_mem_req_we out 1 writeback; o_mem_req_addr out ADDR_W block-aligned; i_mem_req_ready in 1; i_mem_beat_valid in 1 one word transferred.
REQ-008 SHALL have ports: o_data_we out 1; o_data_src out 1 (0 pipeline store, 1 refill); o_data_index out INDEX_W; o_data_word out OFFSET_W.
REQ-009 SHALL have ports: o_hit_count out 32; o_miss_count out 32.

Function
REQ-010 SHALL hold per-set tag, valid, dirty registers; index = addr[INDEX_W+OFFSET_W+1:OFFSET_W+2], word = addr[OFFSET_W+1:2].
REQ-011 SHALL implement FSM IDLE, WB_REQ, WB_DATA, FILL_REQ, FILL_DATA.
REQ-012 IDLE: hit = i_req_valid & valid[idx] & tag match, combinational same cycle; o_hit = hit.
REQ-013 IDLE store hit: o_data_we=1, o_data_src=0, index/word from address, dirty[idx] set next edge.
REQ-014 IDLE miss: victim valid & dirty -> WB_REQ, else -> FILL_REQ; missing address latched.
REQ-015 o_stall_cache = (IDLE & i_req_valid & ~hit) | (state != IDLE), combinational.
REQ-016 WB_REQ: o_mem_req_valid=1, we=1, addr={victim tag, idx, 0}; -> WB_DATA on i_mem_req_ready.
REQ-017 WB_DATA: o_data_word = beat counter (read side); counter increments per i_mem_beat_valid; after beat 2^OFFSET_W-1 -> FILL_REQ, counter wraps to 0.
REQ-018 FILL_REQ: o_mem_req_valid=1, we=0, addr=latched block address, stable until ready; -> FILL_DATA on ready.
REQ-019 FILL_DATA: each beat o_data_we=1, o_data_src=1, o_data_word=counter; last beat writes tag, valid=1, dirty=0, -> IDLE.
REQ-020 Stalled pipeline re-presents request in IDLE after fill; it hits, stall drops same cycle.
REQ-021 i_mem_beat_valid ignored in IDLE, WB_REQ, FILL_REQ; i_mem_req_ready ignored outside *_REQ.
REQ-022 i_req_valid deasserting mid-miss SHALL NOT abort the miss sequence.
REQ-023 o_mem_req_valid SHALL NOT deassert in a *_REQ state before i_mem_req_ready.

Reset
REQ-024 arstn low, any state: state=IDLE, valid/dirty all 0, counter 0, stats 0; outputs 0 except combinational o_stall_cache per REQ-015.
REQ-025 Reset mid-transfer SHALL abandon the transfer without partial tag/valid update.

Configuration
REQ-026 Macro DCACHE_CTRL_STATS_EN defined: o_hit_count/o_miss_count count IDLE hit cycles / miss entries, saturating at 0xFFFFFFFF.
REQ-027 Macro undefined: counters not built, both outputs constant 0, ports retained.

Verification
REQ-028 After reset, load 0x00001040 -> same-cycle stall=1, FILL_REQ addr 0x00001040 we=0; ready, 16 beats with words 0..15 -> next cycle hit=1, stall=0.
REQ-029 Store hit 0x00001044 then load 0x00002040 (same index 1) -> WB_REQ addr 0x00001040 we=1, 16 beats, then FILL_REQ 0x00002040.
REQ-030 Hold i_mem_req_ready low 10 cycles in FILL_REQ -> o_mem_req_valid, addr, stall constant all 10 cycles.
REQ-031 arstn low at FILL_DATA beat 5 -> IDLE, valid cleared; re-issue 0x00001040 -> miss again.
REQ-032 Beats injected during FILL_REQ before ready -> counter stays 0, no o_data_we.
REQ-033 With DCACHE_CTRL_STATS_EN: 1 miss + 2 hits -> hit_count=2, miss_count=1; without macro -> both 0.
